// File: rtl/mc_controller_if.sv
// Control/status bundle between the multi-cycle controller and the MIPS datapath.
// master: the controller (consumes IR fields and memory handshake, drives strobes).
// slave:  the datapath side.
interface mc_controller_if #(
    parameter int COUNT_W = 32
);
    logic               run;
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               mem_ready;

    logic               ir_wr;
    logic               pc_wr;
    logic               reg_dst;
    logic               req_wr;
    logic [2:0]         alu_op;
    logic               alusrc;
    logic               mem_rd;
    logic               mem_wr;
    logic               mem2reg;
    logic               branch;
    logic               jump;
    logic               jr;
    logic [2:0]         state;
    logic [COUNT_W-1:0] instr_count;
    logic               illegal;
    logic               mem_err;

    modport master (
        input  run, opcode, funct, mem_ready,
        output ir_wr, pc_wr, reg_dst, req_wr, alu_op, alusrc, mem_rd, mem_wr,
               mem2reg, branch, jump, jr, state, instr_count, illegal, mem_err
    );

    modport slave (
        output run, opcode, funct, mem_ready,
        input  ir_wr, pc_wr, reg_dst, req_wr, alu_op, alusrc, mem_rd, mem_wr,
               mem2reg, branch, jump, jr, state, instr_count, illegal, mem_err
    );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, datapath
// strobes, bounded data-memory handshake, retired-instruction counter and
// sticky illegal / memory-timeout flags.
module mc_controller #(
    parameter int COUNT_W     = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input logic             clk,
    input logic             rst,
    mc_controller_if.master bus
);
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        K_ILL, K_RALU, K_JR, K_LW, K_SW, K_BEQ, K_ADDI, K_J
    } kind_t;

    typedef struct packed {
        logic       reg_dst;
        logic       req_wr;
        logic [2:0] alu_op;
        logic       alusrc;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem2reg;
        logic       branch;
        logic       jump;
        logic       jr;
    } strobes_t;

    function automatic kind_t decode(input logic [5:0] op, input logic [5:0] fn);
        kind_t k;
        k = K_ILL;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100000, 6'b100010, 6'b100100,
                    6'b100101, 6'b101010: k = K_RALU;
                    6'b001000:            k = K_JR;
                    default:              k = K_ILL;
                endcase
            end
            6'b100011: k = K_LW;
            6'b101011: k = K_SW;
            6'b000100: k = K_BEQ;
            6'b001000: k = K_ADDI;
            6'b000010: k = K_J;
            default:   k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic logic [2:0] alu_of_funct(input logic [5:0] fn);
        logic [2:0] a;
        case (fn)
            6'b100010: a = 3'b001;
            6'b100100: a = 3'b010;
            6'b100101: a = 3'b011;
            6'b101010: a = 3'b100;
            default:   a = 3'b000;
        endcase
        return a;
    endfunction

    // Moore strobe pattern for a state given the captured instruction class.
    function automatic strobes_t strobes_for(input state_t s, input kind_t k,
                                             input logic [5:0] fn);
        strobes_t o;
        o = '0;
        case (s)
            EXEC: begin
                case (k)
                    K_RALU: o.alu_op = alu_of_funct(fn);
                    K_LW, K_SW, K_ADDI: o.alusrc = 1'b1;
                    K_BEQ: begin
                        o.alu_op = 3'b001;
                        o.branch = 1'b1;
                    end
                    K_J:     o.jump = 1'b1;
                    K_JR:    o.jr   = 1'b1;
                    default: o = '0;
                endcase
            end
            MEM: begin
                o.alusrc = 1'b1;
                o.mem_rd = (k == K_LW);
                o.mem_wr = (k == K_SW);
            end
            WB: begin
                o.req_wr = 1'b1;
                case (k)
                    K_LW: begin
                        o.mem2reg = 1'b1;
                        o.reg_dst = 1'b1;
                    end
                    K_ADDI: begin
                        o.reg_dst = 1'b1;
                        o.alusrc  = 1'b1;
                    end
                    K_RALU:  o.alu_op = alu_of_funct(fn);
                    default: o.req_wr = 1'b1;
                endcase
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    state_t             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic [5:0]         fn_q, fn_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [COUNT_W-1:0] count_q;
    logic               illegal_q, mem_err_q;
    strobes_t           strb_q, strb_d;
    kind_t              cur_kind, kind_d;
    logic               retire, set_ill, set_merr;

    assign cur_kind = decode(op_q, fn_q);

    // Next-state, capture and event decode; strobes are precomputed for the
    // state being entered so they can be registered without a cycle of lag.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        fn_d     = fn_q;
        wait_d   = wait_q;
        retire   = 1'b0;
        set_ill  = 1'b0;
        set_merr = 1'b0;
        case (state_q)
            FETCH: begin
                if (bus.run) state_d = DECODE;
            end
            DECODE: begin
                op_d = bus.opcode;
                fn_d = bus.funct;
                if (decode(bus.opcode, bus.funct) == K_ILL) begin
                    set_ill = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (cur_kind)
                    K_BEQ, K_J, K_JR: begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    K_LW, K_SW: begin
                        state_d = MEM;
                        wait_d  = '0;
                    end
                    K_RALU, K_ADDI: state_d = WB;
                    default:        state_d = FETCH;
                endcase
            end
            MEM: begin
                if (bus.mem_ready) begin
                    if (cur_kind == K_SW) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if ((MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
                    set_merr = 1'b1;
                    state_d  = FETCH;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WB: begin
                retire  = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        kind_d = decode(op_d, fn_d);
        strb_d = strobes_for(state_d, kind_d, fn_d);
    end

    // Controller state, captured IR fields, registered strobes and status.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FETCH;
            op_q      <= '0;
            fn_q      <= '0;
            wait_q    <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
            strb_q    <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            fn_q      <= fn_d;
            wait_q    <= wait_d;
            strb_q    <= strb_d;
            illegal_q <= illegal_q | set_ill;
            mem_err_q <= mem_err_q | set_merr;
            if (retire) count_q <= count_q + COUNT_W'(1);
        end
    end

    // Fetch strobes track run directly so a parked controller drives nothing.
    assign bus.ir_wr       = (state_q == FETCH) && bus.run;
    assign bus.pc_wr       = (state_q == FETCH) && bus.run;
    assign bus.reg_dst     = strb_q.reg_dst;
    assign bus.req_wr      = strb_q.req_wr;
    assign bus.alu_op      = strb_q.alu_op;
    assign bus.alusrc      = strb_q.alusrc;
    assign bus.mem_rd      = strb_q.mem_rd;
    assign bus.mem_wr      = strb_q.mem_wr;
    assign bus.mem2reg     = strb_q.mem2reg;
    assign bus.branch      = strb_q.branch;
    assign bus.jump        = strb_q.jump;
    assign bus.jr          = strb_q.jr;
    assign bus.state       = state_q;
    assign bus.instr_count = count_q;
    assign bus.illegal     = illegal_q;
    assign bus.mem_err     = mem_err_q;
endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed scenarios plus randomized instruction
// stream, compared against an instruction-level reference model.
module tb_mc_controller;
    localparam int COUNT_W = 32;
    localparam int T       = 16;

    localparam int ILL = 0, RALU = 1, JR = 2, LW = 3, SW = 4, BEQ = 5, ADDI = 6, JMP = 7;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mc_controller_if #(.COUNT_W(COUNT_W)) bus ();

    mc_controller #(.COUNT_W(COUNT_W), .MEM_TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [COUNT_W-1:0] exp_count;
    logic               exp_ill;
    logic               exp_merr;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] all_strobes();
        return {bus.ir_wr, bus.pc_wr, bus.reg_dst, bus.req_wr, bus.alu_op, bus.alusrc,
                bus.mem_rd, bus.mem_wr, bus.mem2reg, bus.branch, bus.jump, bus.jr};
    endfunction

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) begin
            if (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                fn == 6'b100101 || fn == 6'b101010) return RALU;
            if (fn == 6'b001000) return JR;
            return ILL;
        end
        if (op == 6'b100011) return LW;
        if (op == 6'b101011) return SW;
        if (op == 6'b000100) return BEQ;
        if (op == 6'b001000) return ADDI;
        if (op == 6'b000010) return JMP;
        return ILL;
    endfunction

    function automatic logic [2:0] alu_code(input logic [5:0] fn);
        if (fn == 6'b100010) return 3'b001;
        if (fn == 6'b100100) return 3'b010;
        if (fn == 6'b100101) return 3'b011;
        if (fn == 6'b101010) return 3'b100;
        return 3'b000;
    endfunction

    // Runs one instruction from a FETCH cycle; delay = low mem_ready cycles in MEM.
    // Expected state trace and per-strobe high-cycle totals come from the ISA rules.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int delay, input string name);
        int         q[$];
        int         e[12];
        int         a[12];
        int         kind;
        int         m;
        bit         tmo;
        logic [2:0] alu_exec;
        logic [95:0] ev, av;

        kind = kind_of(op, fn);
        foreach (e[i]) begin
            e[i] = 0;
            a[i] = 0;
        end
        // index: 0 ir 1 pc 2 reg_dst 3 req_wr 4 alu_op!=0 5 alusrc 6 mem_rd
        //        7 mem_wr 8 mem2reg 9 branch 10 jump 11 jr
        e[0] = 1;
        e[1] = 1;
        q = '{0, 1};
        tmo = 1'b0;
        m = 0;
        alu_exec = 3'b000;
        case (kind)
            ILL: exp_ill = 1'b1;
            BEQ: begin
                q.push_back(2); e[9] = 1; e[4] = 1; alu_exec = 3'b001; exp_count++;
            end
            JMP: begin
                q.push_back(2); e[10] = 1; exp_count++;
            end
            JR: begin
                q.push_back(2); e[11] = 1; exp_count++;
            end
            RALU: begin
                q.push_back(2); q.push_back(4); e[3] = 1;
                alu_exec = alu_code(fn);
                e[4] = (alu_exec != 3'b000) ? 2 : 0;
                exp_count++;
            end
            ADDI: begin
                q.push_back(2); q.push_back(4); e[3] = 1; e[2] = 1; e[5] = 2; exp_count++;
            end
            default: begin
                q.push_back(2);
                tmo = (T != 0) && (delay >= T);
                m = tmo ? T : delay + 1;
                for (int i = 0; i < m; i++) q.push_back(3);
                e[5] = 1 + m;
                if (kind == LW) e[6] = m;
                else            e[7] = m;
                if (tmo) begin
                    exp_merr = 1'b1;
                end else if (kind == LW) begin
                    q.push_back(4); e[3] = 1; e[2] = 1; e[8] = 1; exp_count++;
                end else begin
                    exp_count++;
                end
            end
        endcase

        for (int k = 0; k < q.size(); k++) begin
            bus.run    = 1'b1;
            bus.opcode = (k <= 1) ? op : 6'($urandom);
            bus.funct  = (k <= 1) ? fn : 6'($urandom);
            if (q[k] == 3) bus.mem_ready = !tmo && (k == 3 + delay);
            else           bus.mem_ready = 1'($urandom);
            #1;
            chk({name, " state"}, bus.state, q[k]);
            if (k == 2) chk({name, " exec alu_op"}, bus.alu_op, alu_exec);
            a[0]  += int'(bus.ir_wr);
            a[1]  += int'(bus.pc_wr);
            a[2]  += int'(bus.reg_dst);
            a[3]  += int'(bus.req_wr);
            a[4]  += int'(bus.alu_op != 3'b000);
            a[5]  += int'(bus.alusrc);
            a[6]  += int'(bus.mem_rd);
            a[7]  += int'(bus.mem_wr);
            a[8]  += int'(bus.mem2reg);
            a[9]  += int'(bus.branch);
            a[10] += int'(bus.jump);
            a[11] += int'(bus.jr);
            @(negedge clk);
        end
        #1;
        for (int i = 0; i < 12; i++) begin
            ev[i*8 +: 8] = e[i][7:0];
            av[i*8 +: 8] = a[i][7:0];
        end
        chk({name, " strobe counts"}, av, ev);
        chk({name, " back in fetch"}, bus.state, 3'd0);
        chk({name, " instr_count"}, bus.instr_count, exp_count);
        chk({name, " illegal"}, bus.illegal, exp_ill);
        chk({name, " mem_err"}, bus.mem_err, exp_merr);
    endtask

    logic [5:0] tab_op [11];
    logic [5:0] tab_fn [11];

    initial begin
        tab_op = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                   6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        tab_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000,
                   6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};

        rst           = 1'b0;
        bus.run       = 1'b0;
        bus.opcode    = '0;
        bus.funct     = '0;
        bus.mem_ready = 1'b0;
        exp_count     = '0;
        exp_ill       = 1'b0;
        exp_merr      = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset state", bus.state, 3'd0);
        chk("reset strobes", all_strobes(), 14'd0);
        chk("reset instr_count", bus.instr_count, 0);
        chk("reset flags", {bus.illegal, bus.mem_err}, 2'b00);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("parked state", bus.state, 3'd0);
        chk("parked strobes", all_strobes(), 14'd0);

        run_instr(6'b000000, 6'b100000, 0,   "add");
        run_instr(6'b100011, 6'b010101, 3,   "lw wait3");
        run_instr(6'b101011, 6'b000000, 100, "sw timeout");
        run_instr(6'b000100, 6'b000000, 0,   "beq");
        run_instr(6'b000010, 6'b111111, 0,   "j");
        run_instr(6'b000000, 6'b001000, 0,   "jr");
        run_instr(6'b111111, 6'b000000, 0,   "illegal op");
        run_instr(6'b001000, 6'b000000, 0,   "addi after illegal");
        run_instr(6'b000000, 6'b000001, 0,   "illegal funct");
        run_instr(6'b101011, 6'b000000, 15,  "sw last wait");

        for (int n = 0; n < 40; n++) begin
            int         sel;
            logic [5:0] op, fn;
            sel = $urandom_range(0, 11);
            if (sel < 11) begin
                op = tab_op[sel];
                fn = (op == 6'b000000) ? tab_fn[sel] : 6'($urandom);
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            run_instr(op, fn, $urandom_range(0, 20), "random");
        end

        // Reset in the second MEM cycle of a load.
        bus.run       = 1'b1;
        bus.opcode    = 6'b100011;
        bus.funct     = 6'b000000;
        bus.mem_ready = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("mid-mem state", bus.state, 3'd3);
        chk("mid-mem mem_rd", bus.mem_rd, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post-reset state", bus.state, 3'd0);
        chk("post-reset mem_rd", bus.mem_rd, 1'b0);
        chk("post-reset instr_count", bus.instr_count, 0);
        chk("post-reset flags", {bus.illegal, bus.mem_err}, 2'b00);
        chk("post-reset ir_wr follows run", {bus.ir_wr, bus.pc_wr}, 2'b11);
        rst           = 1'b1;
        bus.run       = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("idle state", bus.state, 3'd0);
            chk("idle strobes", all_strobes(), 14'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
